// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and helpers for the
// sequential execute-stage ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NOR  = 5'd11;
  localparam logic [4:0] OP_LUI  = 5'd12;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_LW   = 5'd27;
  localparam logic [4:0] OP_SW   = 5'd28;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  function automatic logic is_multi(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// hi/lo present the result of the iteration retiring this cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] ph;
  logic [WIDTH-1:0] pl;
  logic [WIDTH-1:0] ph_n;
  logic [WIDTH-1:0] pl_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   diff;

  // {ph,pl} is the product/partial-remainder:quotient pair
  always_comb begin
    sum  = {1'b0, ph} + (pl[0] ? {1'b0, opd} : '0);
    rem  = {ph, pl[WIDTH-1]};
    diff = rem - {1'b0, opd};
    if (div) begin
      ph_n = diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0];
      pl_n = {pl[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      ph_n = sum[WIDTH:1];
      pl_n = {sum[0], pl[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign hi   = ph_n;
  assign lo   = pl_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      div  <= 1'b0;
      cnt  <= '0;
      opd  <= '0;
      ph   <= '0;
      pl   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      div  <= mode;
      cnt  <= '0;
      opd  <= mode ? b : a;
      ph   <= '0;
      pl   <= mode ? a : b;
    end else if (busy) begin
      ph  <= ph_n;
      pl  <= pl_n;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered EX-stage ALU with valid/ready handshake and an
// iterative multiply/divide unit feeding architectural HI/LO.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] in_s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  state_t           nxt;
  logic             accept;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign accept = in_valid && in_ready;
  assign shamt  = in_s2[SHW-1:0];

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_multi(alu_opcode)),
    .mode  (alu_opcode == OP_DIV),
    .a     (in_s1),
    .b     (in_s2),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    alu_res = '0;
    case (alu_opcode)
      OP_ADD, OP_LW, OP_SW: alu_res = in_s1 + in_s2;
      OP_SUB:  alu_res = in_s1 - in_s2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(in_s1) < $signed(in_s2)};
      OP_SLL:  alu_res = in_s1 << shamt;
      OP_SRL:  alu_res = in_s1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(in_s1) >>> shamt);
      OP_AND:  alu_res = in_s1 & in_s2;
      OP_OR:   alu_res = in_s1 | in_s2;
      OP_XOR:  alu_res = in_s1 ^ in_s2;
      OP_NOR:  alu_res = ~(in_s1 | in_s2);
      OP_LUI:  alu_res = in_s2 << (WIDTH / 2);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (alu_opcode == OP_DIV)      nxt = DIV;
        else if (alu_opcode == OP_MUL) nxt = MUL;
        else                           nxt = DONE;
      end
      MUL, DIV: if (md_done) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res  <= '0;
      zero <= 1'b1;
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && !is_multi(alu_opcode)) begin
      res  <= alu_res;
      zero <= (alu_res == '0);
    end else if ((state == MUL || state == DIV) && md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
      res  <= md_lo;
      zero <= (md_lo == '0);
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed cases plus random
// traffic against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [4:0]   alu_opcode = '0;
  logic [W-1:0] in_s1 = '0;
  logic [W-1:0] in_s2 = '0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] res;
  logic         zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_opcode (alu_opcode),
    .in_s1      (in_s1),
    .in_s2      (in_s2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res),
    .zero       (zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           seen = 0;
  bit           rnd_rdy = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #2 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural HI/LO pair
  function automatic logic [W-1:0] model(input logic [4:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int unsigned    sh;
    sh = b % W;
    case (op)
      OP_ADD, OP_LW, OP_SW: return a + b;
      OP_SUB: return a - b;
      OP_MUL: begin
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        mhi = p[2*W-1:W];
        mlo = p[W-1:0];
        return mlo;
      end
      OP_DIV: begin
        if (b == 0) begin
          mlo = '1;
          mhi = a;
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
        return mlo;
      end
      OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return W'($signed(a) >>> sh);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_LUI:  return b * (2 ** (W / 2));
      OP_MFHI: return mhi;
      OP_MFLO: return mlo;
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got res %h expected none", res);
      end else begin
        if (!seen) begin
          chk("latency", W'(cyc - q[0].acc), W'(q[0].lat));
          seen = 1;
        end
        if (out_ready) begin
          chk("res", res, q[0].res);
          chk("zero", W'(zero), W'(q[0].res == '0));
          chk("hi", hi, q[0].hi);
          chk("lo", lo, q[0].lo);
          void'(q.pop_front());
          seen = 0;
        end else begin
          chk("held_res", res, q[0].res);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    in_valid   = 1;
    alu_opcode = op;
    in_s1      = a;
    in_s2      = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 op %0d", op);
      in_valid = 0;
      return;
    end
    e.res = model(op, a, b);
    e.hi  = mhi;
    e.lo  = mlo;
    e.acc = cyc;
    e.lat = is_multi(op) ? W + 1 : 1;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
      seen = 0;
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_res", res, '0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
  endtask

  localparam int NOPS = 20;
  logic [4:0] ops [NOPS] = '{
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLT, OP_SLL, OP_SRL,
    OP_SRA, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI, OP_MFHI,
    OP_MFLO, OP_LW, OP_SW, 5'd13, 5'd26, 5'd31
  };

  initial begin
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) @(negedge clk);
    rst = 0;
    check_reset_state();

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(OP_SUB, 32'd5, 32'd5);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SRA, 32'h8000_0000, 32'd4);
    issue(OP_SLL, 32'h0000_0003, 32'h21);
    issue(OP_NOR, 32'h0, 32'h0);
    issue(5'd20, 32'h1234, 32'h5678);
    drain();

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_MFHI, 32'h0, 32'h0);
    issue(OP_DIV, 32'd100, 32'd7);
    issue(OP_DIV, 32'd9, 32'd0);
    issue(OP_MFLO, 32'h0, 32'h0);
    drain();

    // Abort a divide part-way; HI/LO must return to zero
    issue(OP_DIV, 32'hDEAD_BEEF, 32'd13);
    repeat (10) @(negedge clk);
    rst = 1;
    q.delete();
    seen = 0;
    mhi  = '0;
    mlo  = '0;
    @(negedge clk);
    rst = 0;
    check_reset_state();
    issue(OP_ADD, 32'd3, 32'd4);
    drain();

    out_ready = 0;
    issue(OP_ADD, 32'd10, 32'd20);
    fork
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1;
      end
      issue(OP_SUB, 32'd9, 32'd4);
    join
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, NOPS - 1)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) b = '0;
      issue(op, a, b);
    end
    rnd_rdy = 0;
    @(posedge clk);
    #3 out_ready = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
